// File: rtl/regbus_pkg.sv
// rtl/regbus_pkg.sv - shared types and constants for the register-bus initiator
// Contents: state encoding, full-strobe constant, default timeout limit.
package regbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] STRB_FULL          = 4'b1111;
    localparam int         TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/regbus_initiator_if.sv
// rtl/regbus_initiator_if.sv - command/response and peripheral bus bundle
// Ports (signals):
//   command side : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb
//   response side: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   peripheral   : reg_we, reg_re, reg_addr, reg_di, reg_do, ready
// Modports: master = initiator view, slave = environment (requester + peripheral) view.
interface regbus_initiator_if #(
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [3:0]        reg_we;
    logic [3:0]        reg_re;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_di;
    logic [31:0]       reg_do;
    logic              ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  rsp_ready, reg_do, ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output reg_we, reg_re, reg_addr, reg_di
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output rsp_ready, reg_do, ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  reg_we, reg_re, reg_addr, reg_di
    );

endinterface

// File: rtl/regbus_timeout.sv
// rtl/regbus_timeout.sv - wait-cycle counter for the register-bus initiator
// Ports: clk, reset (async, active-high), load_i (clear count), en_i (count this
//        cycle), expired_o (high during the LIMIT-th counted cycle).
module regbus_timeout
    import regbus_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of waiting cycles already completed, so the
    // current cycle is the last allowed one when it equals LIMIT-1.
    assign expired_o = en_i && (count_q == 16'(LIMIT - 1));

endmodule

// File: rtl/regbus_initiator.sv
// rtl/regbus_initiator.sv - single-outstanding register-bus initiator (IDLE/WAIT/RESP)
// Ports: clk, reset (async, active-high), bus (regbus_initiator_if.master).
// Optional feature: REGBUS_TIMEOUT_EN adds a WAIT timeout that answers with rsp_err=1.
module regbus_initiator
    import regbus_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    regbus_initiator_if.master  bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [3:0]        reg_we_q, reg_we_d;
    logic [3:0]        reg_re_q, reg_re_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]       reg_di_q, reg_di_d;
    logic              accept;
    logic              tmo_expired;

    // cmd_ready is registered so it stays low during reset and for the first
    // cycle after release; the accept term therefore also needs cmd_ready_q.
    assign accept = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;

`ifdef REGBUS_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;

    regbus_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .en_i      (state_q == ST_WAIT),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign tmo_expired = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            reg_we_q    <= '0;
            reg_re_q    <= '0;
            reg_addr_q  <= '0;
            reg_di_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            reg_addr_q  <= reg_addr_d;
            reg_di_q    <= reg_di_d;
        end
    end

    // Next-state logic; ready only matters in WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_WAIT;
            ST_WAIT: if (bus.ready || tmo_expired) state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values; everything holds unless the current state updates it
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_rdata_d = rsp_rdata_q;
        reg_we_d    = reg_we_q;
        reg_re_d    = reg_re_q;
        reg_addr_d  = reg_addr_q;
        reg_di_d    = reg_di_q;
`ifdef REGBUS_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    reg_addr_d = bus.cmd_addr;
                    reg_di_d   = bus.cmd_wdata;
                    if (bus.cmd_write) begin
                        // An empty strobe mask means a full-word write
                        reg_we_d = (bus.cmd_wstrb == 4'b0000) ? STRB_FULL : bus.cmd_wstrb;
                        reg_re_d = 4'b0000;
                    end else begin
                        reg_we_d = 4'b0000;
                        reg_re_d = STRB_FULL;
                    end
                end
            end
            ST_WAIT: begin
                // Completion wins over a timeout landing in the same cycle
                if (bus.ready) begin
                    rsp_rdata_d = (reg_re_q != 4'b0000) ? bus.reg_do : 32'd0;
                    reg_we_d    = 4'b0000;
                    reg_re_d    = 4'b0000;
`ifdef REGBUS_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end else if (tmo_expired) begin
                    rsp_rdata_d = 32'd0;
                    reg_we_d    = 4'b0000;
                    reg_re_d    = 4'b0000;
`ifdef REGBUS_TIMEOUT_EN
                    rsp_err_d   = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_di    = reg_di_q;

endmodule

// File: doc/regbus_initiator.md
REGBUS_INITIATOR -- requirements
Module: regbus_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: width of reg_addr and cmd_addr.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: wait-cycle limit; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr, input, ADDR_W bits: register index.
REQ-009 SHALL have port cmd_wdata, input, 32 bits: write data.
REQ-010 SHALL have port cmd_wstrb, input, 4 bits: write byte enables.
REQ-011 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-012 SHALL have port rsp_ready, input, 1 bit: response consumed when high together with rsp_valid.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: the transaction timed out.
REQ-015 SHALL have port reg_we, output, 4 bits: peripheral write strobes.
REQ-016 SHALL have port reg_re, output, 4 bits: peripheral read strobes.
REQ-017 SHALL have port reg_addr, output, ADDR_W bits: peripheral address.
REQ-018 SHALL have port reg_di, output, 32 bits: peripheral write data.
REQ-019 SHALL have port reg_do, input, 32 bits: peripheral read data.
REQ-020 SHALL have port ready, input, 1 bit: peripheral completion.

Function
REQ-021 SHALL implement states IDLE, WAIT and RESP; all bus outputs SHALL be driven from registers.
REQ-022 SHALL assert cmd_ready only in IDLE.
REQ-023 SHALL, on an IDLE accept, move to WAIT on the next edge and register the command: reg_addr=cmd_addr, reg_di=cmd_wdata, and reg_we=cmd_wstrb (write) or reg_re=4'b1111 (read).
REQ-024 SHALL treat a write with cmd_wstrb=0 as a write with wstrb 4'b1111.
REQ-025 SHALL hold reg_we, reg_re, reg_addr and reg_di stable throughout WAIT.
REQ-026 SHALL, on the WAIT edge where ready=1, capture reg_do into rsp_rdata (reads) or 0 (writes), clear rsp_err, clear strobes and enter RESP; read latency from the accept edge to rsp_valid SHALL be 2 cycles for a combinational-ready peripheral.
REQ-027 SHALL ignore ready while in IDLE or RESP.
REQ-028 SHALL hold rsp_valid=1 with stable rsp_rdata and rsp_err in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-029 SHALL allow at most one outstanding transaction; back-to-back throughput SHALL be at most one transaction per 3 cycles.

Reset
REQ-030 SHALL, while reset=1, force IDLE with cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, reg_we=0, reg_re=0, reg_addr=0, reg_di=0 and the timeout counter at 0.
REQ-031 SHALL, when reset asserts mid-transaction, drop strobes immediately without waiting for clk and discard the transaction with no response.

Configuration
REQ-032 SHALL, with REGBUS_TIMEOUT_EN defined, count cycles in WAIT; if ready has not arrived after TIMEOUT_CYCLES cycles, SHALL clear strobes, enter RESP with rsp_err=1 and rsp_rdata=0.
REQ-033 SHALL, when ready=1 arrives in the same cycle the count reaches its limit, complete normally with rsp_err=0.
REQ-034 SHALL, without REGBUS_TIMEOUT_EN, wait indefinitely in WAIT, tie rsp_err to 0 and instantiate no counter.

Structure
REQ-035 SHALL take the state encoding, the 4'b1111 full-strobe constant and the default TIMEOUT_CYCLES from shared package regbus_pkg.
REQ-036 SHALL place the timeout counter in sub-module regbus_timeout (load/enable/expired), instantiated only under REGBUS_TIMEOUT_EN.

Verification
REQ-037 SHALL cover a read with a combinational-ready responder: read at addr 2 returning 0x0000_002A -> rsp_valid 2 cycles after accept, rsp_rdata=0x0000_002A, rsp_err=0.
REQ-038 SHALL cover a write with a registered-ready responder: write at addr 1 with data 0x0000_0005 and wstrb 4'b1111 -> reg_we=4'b1111 held until ready, then rsp_valid with rsp_rdata=0.
REQ-039 SHALL cover response backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable for 5 cycles, and cmd_ready=0 throughout.
REQ-040 SHALL cover timeout with REGBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4 and ready never asserted -> strobes drop after 4 WAIT cycles, rsp_err=1, rsp_rdata=0.
REQ-041 SHALL cover reset mid-transaction: reset asserted 2 cycles into WAIT -> reg_re=0 immediately, no rsp_valid, cmd_ready=1 on the first edge after release.
